// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - fetch-stage branch predictor: direct-mapped BTB with 2-bit counters and a return-address stack
module branch_predictor #(
    parameter int ADDR_SIZE = 32,
    parameter int ENTRIES   = 16,
    parameter int RAS_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [ADDR_SIZE-1:0] pcF,
    output logic                 predtakenF,
    output logic [ADDR_SIZE-1:0] predpcF,
    input  logic                 updE,
    input  logic [ADDR_SIZE-1:0] pcE,
    input  logic                 takenE,
    input  logic [ADDR_SIZE-1:0] targetE,
    input  logic [1:0]           kindE,
    input  logic                 callE
);
    localparam int IDX  = $clog2(ENTRIES);
    localparam int TAGW = ADDR_SIZE - IDX - 2;
    localparam int PW   = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int CW   = $clog2(RAS_DEPTH + 1);

    localparam logic [1:0] KIND_BR  = 2'b00;
    localparam logic [1:0] KIND_JAL = 2'b01;
    localparam logic [1:0] KIND_JR  = 2'b10;
    localparam logic [1:0] KIND_RET = 2'b11;

    logic [ENTRIES-1:0]   validQ;
    logic [TAGW-1:0]      tagQ    [ENTRIES];
    logic [ADDR_SIZE-1:0] targetQ [ENTRIES];
    logic [1:0]           kindQ   [ENTRIES];
    logic [1:0]           ctrQ    [ENTRIES];

    logic [ADDR_SIZE-1:0] rasQ [RAS_DEPTH];
    logic [PW-1:0]        wrPtr;
    logic [CW-1:0]        rasCnt;

    function automatic logic [PW-1:0] ptrInc(input logic [PW-1:0] p);
        return (p == PW'(RAS_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    function automatic logic [PW-1:0] ptrDec(input logic [PW-1:0] p);
        return (p == '0) ? PW'(RAS_DEPTH - 1) : p - PW'(1);
    endfunction

    // wrPtr is the next free slot, so the top of stack sits one below it
    logic [PW-1:0]        topPtr;
    logic [ADDR_SIZE-1:0] rasTop;
    logic                 rasEmpty;
    logic                 rasFull;

    assign topPtr   = ptrDec(wrPtr);
    assign rasTop   = rasQ[topPtr];
    assign rasEmpty = (rasCnt == '0);
    assign rasFull  = (rasCnt == CW'(RAS_DEPTH));

    logic [IDX-1:0]       idxF;
    logic [TAGW-1:0]      tagF;
    logic [ADDR_SIZE-1:0] seqF;
    logic                 hitF;

    assign idxF = pcF[IDX+1:2];
    assign tagF = pcF[ADDR_SIZE-1:IDX+2];
    assign seqF = pcF + ADDR_SIZE'(4);
    assign hitF = !reset && validQ[idxF] && (tagQ[idxF] == tagF);

    always_comb begin
        predtakenF = 1'b0;
        predpcF    = seqF;
        if (hitF) begin
            unique case (kindQ[idxF])
                KIND_BR: begin
                    predtakenF = ctrQ[idxF][1];
                    if (ctrQ[idxF][1]) predpcF = targetQ[idxF];
                end
                KIND_JAL, KIND_JR: begin
                    predtakenF = 1'b1;
                    predpcF    = targetQ[idxF];
                end
                KIND_RET: begin
                    if (!rasEmpty) begin
                        predtakenF = 1'b1;
                        predpcF    = rasTop;
                    end
                end
            endcase
        end
    end

    logic [IDX-1:0]       idxE;
    logic [TAGW-1:0]      tagE;
    logic [ADDR_SIZE-1:0] retE;
    logic                 hitE;
    logic                 doPush;
    logic                 doPop;
    logic                 doReplace;

    assign idxE = pcE[IDX+1:2];
    assign tagE = pcE[ADDR_SIZE-1:IDX+2];
    assign retE = pcE + ADDR_SIZE'(4);
    assign hitE = validQ[idxE] && (tagQ[idxE] == tagE);

    assign doPop     = updE && (kindE == KIND_RET) && !callE && !rasEmpty;
    assign doPush    = updE && callE && ((kindE != KIND_RET) || rasEmpty);
    assign doReplace = updE && callE && (kindE == KIND_RET) && !rasEmpty;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            validQ <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                tagQ[i]    <= '0;
                targetQ[i] <= '0;
                kindQ[i]   <= KIND_BR;
                ctrQ[i]    <= 2'b00;
            end
            for (int j = 0; j < RAS_DEPTH; j++) rasQ[j] <= '0;
            wrPtr  <= '0;
            rasCnt <= '0;
        end else begin
            if (updE) begin
                if (hitE) begin
                    if (kindQ[idxE] == KIND_BR) begin
                        if (takenE) begin
                            if (ctrQ[idxE] != 2'b11) ctrQ[idxE] <= ctrQ[idxE] + 2'b01;
                            targetQ[idxE] <= targetE;
                        end else if (ctrQ[idxE] != 2'b00) begin
                            ctrQ[idxE] <= ctrQ[idxE] - 2'b01;
                        end
                    end else begin
                        targetQ[idxE] <= targetE;
                        kindQ[idxE]   <= kindE;
                    end
                end else if (takenE) begin
                    // allocation evicts whatever alias occupied this index
                    validQ[idxE]  <= 1'b1;
                    tagQ[idxE]    <= tagE;
                    targetQ[idxE] <= targetE;
                    kindQ[idxE]   <= kindE;
                    ctrQ[idxE]    <= 2'b10;
                end
            end

            if (doPush) begin
                rasQ[wrPtr] <= retE;
                wrPtr       <= ptrInc(wrPtr);
                if (!rasFull) rasCnt <= rasCnt + CW'(1);
            end else if (doReplace) begin
                rasQ[topPtr] <= retE;
            end else if (doPop) begin
                wrPtr  <= topPtr;
                rasCnt <= rasCnt - CW'(1);
            end
        end
    end
endmodule

// File: tb/tb_branch_predictor.sv
// tb/tb_branch_predictor.sv - scoreboard bench for branch_predictor
module tb_branch_predictor;
    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pcF;
    logic        predtakenF;
    logic [31:0] predpcF;
    logic        updE;
    logic [31:0] pcE;
    logic        takenE;
    logic [31:0] targetE;
    logic [1:0]  kindE;
    logic        callE;

    branch_predictor #(.ADDR_SIZE(32), .ENTRIES(16), .RAS_DEPTH(4)) dut (
        .clk(clk), .reset(reset), .pcF(pcF), .predtakenF(predtakenF), .predpcF(predpcF),
        .updE(updE), .pcE(pcE), .takenE(takenE), .targetE(targetE), .kindE(kindE), .callE(callE)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        taken;
        logic [31:0] pc;
        string       name;
    } exp_t;

    exp_t expQ[$];
    int   passCnt  = 0;
    int   totalCnt = 0;
    bit   stimDone = 1'b0;

    // Monitor: outputs are combinational, so each queued expectation is checked at the next falling edge
    initial begin
        forever begin
            @(negedge clk);
            while (expQ.size() > 0) begin
                exp_t e;
                e = expQ.pop_front();
                totalCnt++;
                if (predtakenF === e.taken && predpcF === e.pc) passCnt++;
                else $display("FAIL %s: got taken=%0b pc=%h, expected taken=%0b pc=%h",
                              e.name, predtakenF, predpcF, e.taken, e.pc);
            end
        end
    end

    task automatic look(input logic [31:0] pc, input logic t, input logic [31:0] p, input string name);
        exp_t e;
        pcF = pc;
        e.taken = t; e.pc = p; e.name = name;
        expQ.push_back(e);
        @(posedge clk); #1;
    endtask

    task automatic upd(input logic [31:0] pc, input logic t, input logic [31:0] tgt,
                       input logic [1:0] k, input logic c);
        updE = 1'b1; pcE = pc; takenE = t; targetE = tgt; kindE = k; callE = c;
        @(posedge clk); #1;
        updE = 1'b0; callE = 1'b0;
    endtask

    task automatic pop();
        upd(32'h2010, 1'b1, 32'h0, 2'b11, 1'b0);
    endtask

    initial begin
        reset = 1'b1; pcF = 32'h40; updE = 1'b0; pcE = '0; takenE = 1'b0;
        targetE = '0; kindE = 2'b00; callE = 1'b0;
        #2;
        look(32'h40, 1'b0, 32'h44, "reset_held");
        reset = 1'b0;
        @(posedge clk); #1;
        look(32'h40, 1'b0, 32'h44, "after_reset");
        look(32'hFFFF_FFFC, 1'b0, 32'h0, "seq_wrap");

        upd(32'h100, 1'b1, 32'h80, 2'b00, 1'b0);
        look(32'h100, 1'b1, 32'h80, "br_alloc_ctr10");
        upd(32'h100, 1'b0, 32'h80, 2'b00, 1'b0);
        look(32'h100, 1'b0, 32'h104, "br_ctr01");
        upd(32'h100, 1'b1, 32'h80, 2'b00, 1'b0);
        look(32'h100, 1'b1, 32'h80, "br_ctr10");
        upd(32'h100, 1'b1, 32'h80, 2'b00, 1'b0);
        upd(32'h100, 1'b1, 32'h80, 2'b00, 1'b0);
        upd(32'h100, 1'b0, 32'h80, 2'b00, 1'b0);
        look(32'h100, 1'b1, 32'h80, "br_sat11_then_nt");
        upd(32'h100, 1'b0, 32'h80, 2'b00, 1'b0);
        look(32'h100, 1'b0, 32'h104, "br_ctr01_again");

        upd(32'h140, 1'b1, 32'h200, 2'b01, 1'b0);
        look(32'h100, 1'b0, 32'h104, "alias_evicted");
        look(32'h140, 1'b1, 32'h200, "alias_new");

        upd(32'h300, 1'b0, 32'h380, 2'b00, 1'b0);
        look(32'h300, 1'b0, 32'h304, "nt_miss_no_alloc");
        look(32'h140, 1'b1, 32'h200, "nt_miss_keeps_alias");

        upd(32'h1000, 1'b1, 32'h2000, 2'b01, 1'b1);
        upd(32'h3000, 1'b1, 32'h2000, 2'b01, 1'b1);
        upd(32'h2010, 1'b1, 32'h3004, 2'b11, 1'b0);
        look(32'h2010, 1'b1, 32'h1004, "ret_after_pop");
        pop();
        look(32'h2010, 1'b0, 32'h2014, "ret_empty");

        for (int i = 0; i < 5; i++) upd(32'h5000 + 32'(i) * 32'h100, 1'b1, 32'h2000, 2'b01, 1'b1);
        look(32'h2010, 1'b1, 32'h5404, "ovf_E");
        pop();
        look(32'h2010, 1'b1, 32'h5304, "ovf_D");
        pop();
        look(32'h2010, 1'b1, 32'h5204, "ovf_C");
        pop();
        look(32'h2010, 1'b1, 32'h5104, "ovf_B");
        pop();
        look(32'h2010, 1'b0, 32'h2014, "ovf_A_lost");
        pop();
        look(32'h2010, 1'b0, 32'h2014, "pop_empty_noop");
        upd(32'h6000, 1'b1, 32'h2000, 2'b01, 1'b1);
        look(32'h2010, 1'b1, 32'h6004, "push_after_empty_pop");
        pop();
        look(32'h2010, 1'b0, 32'h2014, "single_pop");

        upd(32'h7000, 1'b1, 32'h2000, 2'b01, 1'b1);
        upd(32'h7100, 1'b1, 32'h2000, 2'b11, 1'b1);
        look(32'h2010, 1'b1, 32'h7104, "ret_call_replace");
        pop();
        look(32'h2010, 1'b0, 32'h2014, "replace_kept_count");

        upd(32'h8000, 1'b1, 32'h2000, 2'b01, 1'b1);
        look(32'h2010, 1'b1, 32'h8004, "pre_reset_trained");
        pcF = 32'h2010;
        reset = 1'b1;
        look(32'h2010, 1'b0, 32'h2014, "async_reset_mid_run");
        reset = 1'b0;
        @(posedge clk); #1;
        look(32'h2010, 1'b0, 32'h2014, "post_reset_cleared");
        look(32'h140, 1'b0, 32'h144, "post_reset_btb_cleared");

        @(negedge clk); #1;
        if (expQ.size() != 0) begin
            totalCnt++;
            $display("FAIL drain: got %0d pending, expected 0", expQ.size());
        end
        stimDone = 1'b1;
        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

    initial begin
        #200000;
        if (!stimDone) begin
            $display("FAIL timeout: got no completion, expected completion within 200000");
            $fatal(1);
        end
    end
endmodule
